// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg: shared widths and requester-select encoding for the register-file write arbiter.
package wb_port_arbiter_pkg;
  localparam int REG_IDX_W = 4;
  localparam int NUM_REGS = 16;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {REQ_NONE, REQ_PIPE, REQ_LD, REQ_DBG} req_sel_e;
endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: pending-load mask and operand hazard lookup.
module wb_scoreboard
  import wb_port_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_en,
  input  logic [REG_IDX_W-1:0] set_idx,
  input  logic                 clr_en,
  input  logic [REG_IDX_W-1:0] clr_idx,
  input  logic [REG_IDX_W-1:0] src1,
  input  logic [REG_IDX_W-1:0] src2,
  input  logic                 two_src,
  output logic                 hit
);
  logic [NUM_REGS-1:0] pending;
  // set is applied after clear so a same-cycle issue and return keeps the bit
  always_ff @(posedge clk or posedge rst)
    if (rst) pending <= '0;
    else pending <= (pending & ~(NUM_REGS'(clr_en) << clr_idx)) | (NUM_REGS'(set_en) << set_idx);
  assign hit = pending[src1] | (two_src & pending[src2]);
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares one register-file write port between the pipeline, load returns and debug writes.
// Debug requester and round-robin exist only when WB_ARB_DEBUG_EN is defined.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pipe_wb_en,
  input  logic [REG_IDX_W-1:0] pipe_wb_dest,
  input  logic [DATA_W-1:0]    pipe_wb_value,
  input  logic                 ld_req,
  input  logic [REG_IDX_W-1:0] ld_dest,
  input  logic [DATA_W-1:0]    ld_value,
  output logic                 ld_ack,
  input  logic                 dbg_req,
  input  logic [REG_IDX_W-1:0] dbg_dest,
  input  logic [DATA_W-1:0]    dbg_value,
  output logic                 dbg_ack,
  input  logic                 issue_ld,
  input  logic [REG_IDX_W-1:0] issue_dest,
  input  logic [REG_IDX_W-1:0] src1,
  input  logic [REG_IDX_W-1:0] src2,
  input  logic                 two_src,
  output logic                 WB_WB_EN,
  output logic [REG_IDX_W-1:0] wbDest,
  output logic [DATA_W-1:0]    WB_Value,
  output logic                 Hazard
);
  localparam int CW = $clog2(STARVE_LIMIT) + 1;
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
  req_sel_e sel;
  logic [CW-1:0] ld_cnt;
  logic [REG_IDX_W-1:0] sb_dest;
  logic [DATA_W-1:0] sb_value;
  logic hit, starve;
  function automatic logic [CW-1:0] wait_next(input logic req, input logic ack, input logic [CW-1:0] c);
    return (!req || ack) ? '0 : (c == LIM) ? c : c + 1'b1;
  endfunction
`ifdef WB_ARB_DEBUG_EN
  logic rr;
  logic [CW-1:0] dbg_cnt;
  always_comb sel = pipe_wb_en ? REQ_PIPE : (ld_req && dbg_req) ? (rr ? REQ_DBG : REQ_LD) :
                    ld_req ? REQ_LD : dbg_req ? REQ_DBG : REQ_NONE;
  // a contested grant always hands priority to the loser, i.e. a plain toggle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rr <= 1'b0;
      dbg_cnt <= '0;
    end else begin
      if (!pipe_wb_en && ld_req && dbg_req) rr <= ~rr;
      dbg_cnt <= wait_next(dbg_req, dbg_ack, dbg_cnt);
    end
  assign dbg_ack = sel == REQ_DBG;
  assign sb_dest = dbg_ack ? dbg_dest : ld_dest;
  assign sb_value = dbg_ack ? dbg_value : ld_value;
  assign starve = (ld_cnt == LIM) || (dbg_cnt == LIM);
`else
  logic unused_dbg;
  always_comb sel = pipe_wb_en ? REQ_PIPE : ld_req ? REQ_LD : REQ_NONE;
  assign dbg_ack = 1'b0;
  assign sb_dest = ld_dest;
  assign sb_value = ld_value;
  assign starve = ld_cnt == LIM;
  assign unused_dbg = ^{dbg_req, dbg_dest, dbg_value};
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) ld_cnt <= '0;
    else ld_cnt <= wait_next(ld_req, ld_ack, ld_cnt);
  assign ld_ack = sel == REQ_LD;
  assign WB_WB_EN = sel != REQ_NONE;
  assign wbDest = (sel == REQ_PIPE) ? pipe_wb_dest : (sel == REQ_NONE) ? '0 : sb_dest;
  assign WB_Value = (sel == REQ_PIPE) ? pipe_wb_value : (sel == REQ_NONE) ? '0 : sb_value;
  wb_scoreboard u_sb (
    .clk(clk), .rst(rst),
    .set_en(issue_ld), .set_idx(issue_dest),
    .clr_en(ld_ack), .clr_idx(ld_dest),
    .src1(src1), .src2(src2), .two_src(two_src),
    .hit(hit)
  );
  assign Hazard = hit | starve;
endmodule
